// File: rtl/iterative_alu_unit_pkg.sv
// Shared op codes, FSM states, opcode/funct7 constants and decode helpers.
// ALU_DIVIDER_EN enables the DIVU/REMU decode and the DIV state.
package iterative_alu_unit_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_SLT  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_SLL  = 4'b1010,
    OP_SRL  = 4'b1011,
    OP_SRA  = 4'b1100,
    OP_MUL  = 4'b1101,
    OP_DIVU = 4'b1110,
    OP_REMU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_DIVIDER_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_ARITH_I = 7'b0010011;
  localparam logic [6:0] OPC_ARITH   = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;

  localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Base integer decode shared by I- and R-type; sub_en is only set for R-type.
  function automatic alu_op_e dec_arith(input logic [2:0] f3, input logic alt,
                                        input logic sub_en);
    alu_op_e op;
    op = OP_ADD;
    case (f3)
      3'b000: op = sub_en ? OP_SUB : OP_ADD;
      3'b001: op = OP_SLL;
      3'b010: op = OP_SLT;
      3'b011: op = OP_SLTU;
      3'b100: op = OP_XOR;
      3'b101: op = alt ? OP_SRA : OP_SRL;
      3'b110: op = OP_OR;
      3'b111: op = OP_AND;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  function automatic alu_op_e dec_m(input logic [2:0] f3);
    alu_op_e op;
    op = OP_ADD;
    case (f3)
      3'b000: op = OP_MUL;
`ifdef ALU_DIVIDER_EN
      3'b101: op = OP_DIVU;
      3'b111: op = OP_REMU;
`endif
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  function automatic alu_op_e dec_branch(input logic [2:0] f3);
    alu_op_e op;
    op = OP_ADD;
    case (f3)
      3'b000, 3'b001: op = OP_SUB;
      3'b100, 3'b101: op = OP_SLT;
      3'b110, 3'b111: op = OP_SLTU;
      default:        op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/iterative_alu_unit_alu_op_decode.sv
// Combinational instruction-field / alu_ctrl_op to ALU op-code decoder.
// Also used by the hazard unit; DIVU/REMU only decode when ALU_DIVIDER_EN is defined.
module alu_op_decode
  import iterative_alu_unit_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [1:0] ctrl_i,
  output alu_op_e    alu_op_o
);

  logic    m_op;
  alu_op_e r_op;

  assign m_op = (opcode_i == OPC_ARITH) && (funct7_i == FUNCT7_MULDIV);

  always_comb begin
    r_op     = m_op ? dec_m(funct3_i)
                    : dec_arith(funct3_i, funct7_i[5], funct7_i == FUNCT7_SUB);
    alu_op_o = OP_ADD;
    case (ctrl_i)
      2'b00: alu_op_o = OP_ADD;
      2'b01: alu_op_o = dec_arith(funct3_i, funct7_i[5], 1'b0);
      2'b10: alu_op_o = r_op;
      2'b11: begin
        case (opcode_i)
          OPC_ARITH:   alu_op_o = r_op;
          OPC_ARITH_I: alu_op_o = dec_arith(funct3_i, funct7_i[5], 1'b0);
          OPC_BRANCH:  alu_op_o = dec_branch(funct3_i);
          default:     alu_op_o = OP_ADD;  // LOAD/STORE/JALR and anything unmapped
        endcase
      end
      default: alu_op_o = OP_ADD;
    endcase
  end

endmodule

// File: rtl/iterative_alu_unit.sv
// Handshaked execute block: single-cycle ALU ops, iterative shift-add MUL and,
// with ALU_DIVIDER_EN defined, an iterative restoring DIVU/REMU.
module iterative_alu_unit
  import iterative_alu_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [1:0]      alu_ctrl_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_op,
  output logic            cmp_true
);

  state_e            state_q;
  logic              in_ready_q, out_valid_q, cmp_q;
  logic [XLEN-1:0]   result_q, a_q, b_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;
  alu_op_e           alu_op_q, dec_op;

  logic [XLEN-1:0]   alu_res_d, mul_acc_d;
  logic              cmp_d, last_iter;
  logic [CNT_W-2:0]  shamt;
  logic              unused_inst_bits;

  alu_op_decode u_decode (
    .opcode_i (inst[6:0]),
    .funct3_i (inst[14:12]),
    .funct7_i (inst[31:25]),
    .ctrl_i   (alu_ctrl_op),
    .alu_op_o (dec_op)
  );

  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};
  assign shamt     = op_b[CNT_W-2:0];
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
  // Multiplicand/multiplier shift each step, so bit i adds op_a<<i.
  assign mul_acc_d = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    alu_res_d = '0;
    case (dec_op)
      OP_ADD:  alu_res_d = op_a + op_b;
      OP_SUB:  alu_res_d = op_a - op_b;
      OP_AND:  alu_res_d = op_a & op_b;
      OP_OR:   alu_res_d = op_a | op_b;
      OP_XOR:  alu_res_d = op_a ^ op_b;
      OP_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_SLL:  alu_res_d = op_a << shamt;
      OP_SRL:  alu_res_d = op_a >> shamt;
      OP_SRA:  alu_res_d = $unsigned($signed(op_a) >>> shamt);
      default: alu_res_d = '0;
    endcase
  end

  always_comb begin
    cmp_d = 1'b0;
    if (inst[6:0] == OPC_BRANCH) begin
      case (inst[14:12])
        3'b000:  cmp_d = (op_a == op_b);
        3'b001:  cmp_d = (op_a != op_b);
        3'b100:  cmp_d = ($signed(op_a) <  $signed(op_b));
        3'b101:  cmp_d = ($signed(op_a) >= $signed(op_b));
        3'b110:  cmp_d = (op_a <  op_b);
        3'b111:  cmp_d = (op_a >= op_b);
        default: cmp_d = 1'b0;
      endcase
    end
  end

`ifdef ALU_DIVIDER_EN
  // Restoring step: a_q shifts the dividend out and the quotient in; acc_q is the remainder.
  logic [XLEN:0]   div_trial;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_d, div_quo_d;

  assign div_trial = {acc_q, a_q[XLEN-1]};
  assign div_ge    = (div_trial >= {1'b0, b_q});
  assign div_rem_d = div_ge ? XLEN'(div_trial - {1'b0, b_q}) : div_trial[XLEN-1:0];
  assign div_quo_d = {a_q[XLEN-2:0], div_ge};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      alu_op_q    <= OP_ADD;
      cmp_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            alu_op_q   <= dec_op;
            cmp_q      <= cmp_d;
            a_q        <= op_a;
            b_q        <= op_b;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (dec_op == OP_MUL) begin
              state_q <= S_MUL;
            end
`ifdef ALU_DIVIDER_EN
            else if (dec_op == OP_DIVU || dec_op == OP_REMU) begin
              state_q <= S_DIV;
            end
`endif
            else begin
              result_q    <= alu_res_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            result_q    <= mul_acc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`ifdef ALU_DIVIDER_EN
        S_DIV: begin
          acc_q <= div_rem_d;
          a_q   <= div_quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            result_q    <= (alu_op_q == OP_DIVU) ? div_quo_d : div_rem_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign alu_op    = alu_op_q;
  assign cmp_true  = cmp_q;

endmodule

// File: tb/tb_iterative_alu_unit.sv
// Directed bench for iterative_alu_unit; DIVU/REMU vectors switch with ALU_DIVIDER_EN.
module tb_iterative_alu_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     inst = '0;
  logic [1:0]      alu_ctrl_op = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic [3:0]      alu_op;
  logic            cmp_true;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h0000_0033;
  localparam logic [31:0] I_MUL  = 32'h0200_0033;
  localparam logic [31:0] I_DIVU = 32'h0200_5033;
  localparam logic [31:0] I_REMU = 32'h0200_7033;

  typedef struct {
    string       name;
    logic [1:0]  ctrl;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  op;
    logic        cmp;
  } vec_t;

  iterative_alu_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst        (inst),
    .alu_ctrl_op (alu_ctrl_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .alu_op      (alu_op),
    .cmp_true    (cmp_true)
  );

  always #5 clk = ~clk;

  // Present one request for one edge; lat counts cycles until out_valid (1 = next cycle).
  task automatic issue(input logic [1:0] ctrl, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl_op = ctrl; inst = ins; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if (alu_op !== 4'b0000) begin n_err++; $display("FAIL reset_alu_op: got %b want 0000", alu_op); end
    n_cmp++; if (cmp_true !== 1'b0) begin n_err++; $display("FAIL reset_cmp: got %b want 0", cmp_true); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_alu_ops;
    vec_t v[$];
    int   lat;
    v.push_back('{"add",      2'b10, 32'h0000_0033, 32'd5,         32'd7,         32'd12,        4'b0000, 1'b0});
    v.push_back('{"sub",      2'b10, 32'h4000_0033, 32'd5,         32'd7,         32'hFFFF_FFFE, 4'b0001, 1'b0});
    v.push_back('{"sra",      2'b10, 32'h4000_5033, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b1100, 1'b0});
    v.push_back('{"srl",      2'b10, 32'h0000_5033, 32'h8000_0000, 32'd4,         32'h0800_0000, 4'b1011, 1'b0});
    v.push_back('{"srai",     2'b01, 32'h4000_5013, 32'hF000_0000, 32'd8,         32'hFFF0_0000, 4'b1100, 1'b0});
    v.push_back('{"sltu",     2'b10, 32'h0000_3033, 32'd1,         32'hFFFF_FFFF, 32'd1,         4'b0111, 1'b0});
    v.push_back('{"slt",      2'b10, 32'h0000_2033, 32'd1,         32'hFFFF_FFFF, 32'd0,         4'b0110, 1'b0});
    v.push_back('{"sll_mask", 2'b10, 32'h0000_1033, 32'd1,         32'd35,        32'd8,         4'b1010, 1'b0});
    v.push_back('{"xor",      2'b10, 32'h0000_4033, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 4'b1000, 1'b0});
    v.push_back('{"and",      2'b10, 32'h0000_7033, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 4'b0100, 1'b0});
    v.push_back('{"force_add",2'b00, 32'h4000_0033, 32'd5,         32'd7,         32'd12,        4'b0000, 1'b0});
    v.push_back('{"load_add", 2'b11, 32'h0000_2003, 32'h100,       32'd4,         32'h104,       4'b0000, 1'b0});
    v.push_back('{"mulh_add", 2'b10, 32'h0200_1033, 32'd2,         32'd3,         32'd5,         4'b0000, 1'b0});
    v.push_back('{"add_wrap", 2'b10, 32'h0000_0033, 32'hFFFF_FFFF, 32'd2,         32'd1,         4'b0000, 1'b0});
`ifndef ALU_DIVIDER_EN
    v.push_back('{"divu_off", 2'b10, I_DIVU,        32'd100,       32'd7,         32'd107,       4'b0000, 1'b0});
`endif
    foreach (v[i]) begin
      issue(v[i].ctrl, v[i].ins, v[i].a, v[i].b, lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL %s_latency: got %0d want 1", v[i].name, lat); end
      n_cmp++; if (result !== v[i].res) begin n_err++; $display("FAIL %s_result: got %h want %h", v[i].name, result, v[i].res); end
      n_cmp++; if (alu_op !== v[i].op) begin n_err++; $display("FAIL %s_alu_op: got %b want %b", v[i].name, alu_op, v[i].op); end
      n_cmp++; if (cmp_true !== v[i].cmp) begin n_err++; $display("FAIL %s_cmp: got %b want %b", v[i].name, cmp_true, v[i].cmp); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s_busy_in_ready: got %b want 0", v[i].name, in_ready); end
      consume();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL %s_release: got out_valid=%b in_ready=%b want 0/1", v[i].name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_branch;
    vec_t v[$];
    int   lat;
    v.push_back('{"blt",  2'b11, 32'h0000_4063, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0110, 1'b1});
    v.push_back('{"bltu", 2'b11, 32'h0000_6063, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0111, 1'b0});
    v.push_back('{"bge",  2'b11, 32'h0000_5063, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0110, 1'b0});
    v.push_back('{"bgeu", 2'b11, 32'h0000_7063, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0111, 1'b1});
    v.push_back('{"beq",  2'b11, 32'h0000_0063, 32'd3,         32'd3, 32'd0, 4'b0001, 1'b1});
    v.push_back('{"bne",  2'b11, 32'h0000_1063, 32'd3,         32'd3, 32'd0, 4'b0001, 1'b0});
    foreach (v[i]) begin
      issue(v[i].ctrl, v[i].ins, v[i].a, v[i].b, lat);
      n_cmp++; if (result !== v[i].res) begin n_err++; $display("FAIL %s_result: got %h want %h", v[i].name, result, v[i].res); end
      n_cmp++; if (alu_op !== v[i].op) begin n_err++; $display("FAIL %s_alu_op: got %b want %b", v[i].name, alu_op, v[i].op); end
      n_cmp++; if (cmp_true !== v[i].cmp) begin n_err++; $display("FAIL %s_cmp: got %b want %b", v[i].name, cmp_true, v[i].cmp); end
      consume();
    end
  endtask

  task automatic test_mul;
    int lat = 1;
    int low = 0;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl_op = 2'b10; inst = I_MUL; op_a = 32'hFFFF_FFFF; op_b = 32'd3;
    @(posedge clk); #1;
    // Keep a competing ADD request asserted while busy; it must be ignored.
    inst = I_ADD; op_a = 32'd1; op_b = 32'd1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready === 1'b0) low++;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (in_ready === 1'b0) low++;
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency: got %0d want 33", lat); end
    n_cmp++; if (low !== 33) begin n_err++; $display("FAIL mul_in_ready_low: got %0d want 33", low); end
    n_cmp++; if (result !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mul_result: got %h want fffffffd", result); end
    n_cmp++; if (alu_op !== 4'b1101) begin n_err++; $display("FAIL mul_alu_op: got %b want 1101", alu_op); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFD) begin
      n_err++; $display("FAIL mul_hold: got out_valid=%b result=%h want 1/fffffffd", out_valid, result);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_done_no_accept: got in_ready=%b want 0", in_ready); end
    consume();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL mul_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    issue(2'b10, I_MUL, 32'd12345, 32'd0, lat);
    n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL mul_by_zero: got %h want 0", result); end
    consume();
    issue(2'b10, I_MUL, 32'h0001_0001, 32'h0001_0003, lat);
    n_cmp++; if (result !== 32'h0004_0003) begin n_err++; $display("FAIL mul_wrap: got %h want 00040003", result); end
    consume();
  endtask

`ifdef ALU_DIVIDER_EN
  task automatic test_div;
    vec_t v[$];
    int   lat;
    v.push_back('{"divu",      2'b10, I_DIVU, 32'd100,       32'd7, 32'd14,        4'b1110, 1'b0});
    v.push_back('{"remu",      2'b10, I_REMU, 32'd100,       32'd7, 32'd2,         4'b1111, 1'b0});
    v.push_back('{"divu_zero", 2'b10, I_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 4'b1110, 1'b0});
    v.push_back('{"remu_zero", 2'b10, I_REMU, 32'd9,         32'd0, 32'd9,         4'b1111, 1'b0});
    v.push_back('{"divu_big",  2'b10, I_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 4'b1110, 1'b0});
    foreach (v[i]) begin
      issue(v[i].ctrl, v[i].ins, v[i].a, v[i].b, lat);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL %s_latency: got %0d want 33", v[i].name, lat); end
      n_cmp++; if (result !== v[i].res) begin n_err++; $display("FAIL %s_result: got %h want %h", v[i].name, result, v[i].res); end
      n_cmp++; if (alu_op !== v[i].op) begin n_err++; $display("FAIL %s_alu_op: got %b want %b", v[i].name, alu_op, v[i].op); end
      consume();
    end
  endtask
`endif

  task automatic test_reset_abort;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl_op = 2'b10; inst = I_MUL; op_a = 32'd7; op_b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_handshake: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_cmp++; if (alu_op !== 4'b0000 || result !== 32'h0) begin
      n_err++; $display("FAIL abort_outputs: got alu_op=%b result=%h want 0000/0", alu_op, result);
    end
    @(negedge clk); reset = 1'b0;
    issue(2'b10, I_ADD, 32'd1, 32'd1, lat);
    n_cmp++; if (lat !== 1 || result !== 32'd2) begin
      n_err++; $display("FAIL abort_next_add: got lat=%0d result=%h want 1/2", lat, result);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branch();
    test_mul();
`ifdef ALU_DIVIDER_EN
    test_div();
`endif
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
